// File: rtl/lsu_mem_initiator_pkg.sv
// Shared types and constants for the LSU-to-memory-bus initiator: FSM states, access sizes,
// address region decode and write-strobe generation.
package lsu_mem_initiator_pkg;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  typedef enum logic [1:0] {SizeB, SizeH, SizeW, SizeD} size_e;

  localparam logic [3:0]  RegionSram = 4'h8;
  localparam logic [3:0]  RegionAxi  = 4'h9;
  localparam logic [63:0] RegionMask = 64'h0000_0000_0FFF_FFFF;

  // Mapped iff the top nibble of the low 32 bits selects SRAM or AXI and bits 63:32 are zero.
  function automatic logic addr_mapped(logic [63:0] addr);
    logic [63:0] masked;
    masked = addr | RegionMask;
    return (masked == {32'h0, RegionSram, 28'hFFF_FFFF}) ||
           (masked == {32'h0, RegionAxi, 28'hFFF_FFFF});
  endfunction

  function automatic logic [7:0] size_to_wstrb(size_e size, logic wen);
    logic [7:0] strb;
    case (size)
      SizeB:   strb = 8'h01;
      SizeH:   strb = 8'h03;
      SizeW:   strb = 8'h0F;
      default: strb = 8'hFF;
    endcase
    return wen ? strb : 8'h00;
  endfunction

endpackage

// File: rtl/lsu_mem_initiator_if.sv
// LSU pipeline and memory bus signals of the initiator; master is the initiator's view,
// slave is the view of the LSU pipeline plus bus responder.
interface lsu_mem_initiator_if;

  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [63:0] lsu_req_addr;
  logic [63:0] lsu_req_wdata;
  logic [1:0]  lsu_req_size;
  logic        lsu_req_wen;
  logic        lsu_req_unsigned;

  logic        lsu_rsp_valid;
  logic        lsu_rsp_ready;
  logic [63:0] lsu_rsp_data;
  logic        lsu_rsp_err;

  logic        mem_mstReq_valid;
  logic        mem_mstReq_ready;
  logic [63:0] mem_addr;
  logic [63:0] mem_data_w;
  logic [7:0]  mem_wstrb;
  logic        mem_wen;
  logic [63:0] mem_data_r;
  logic        mem_slvRsp_valid;

  modport master (
    input  lsu_req_valid, lsu_req_addr, lsu_req_wdata, lsu_req_size, lsu_req_wen,
           lsu_req_unsigned, lsu_rsp_ready, mem_mstReq_ready, mem_data_r, mem_slvRsp_valid,
    output lsu_req_ready, lsu_rsp_valid, lsu_rsp_data, lsu_rsp_err, mem_mstReq_valid,
           mem_addr, mem_data_w, mem_wstrb, mem_wen
  );

  modport slave (
    output lsu_req_valid, lsu_req_addr, lsu_req_wdata, lsu_req_size, lsu_req_wen,
           lsu_req_unsigned, lsu_rsp_ready, mem_mstReq_ready, mem_data_r, mem_slvRsp_valid,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_data, lsu_rsp_err, mem_mstReq_valid,
           mem_addr, mem_data_w, mem_wstrb, mem_wen
  );

endinterface

// File: rtl/lsu_mem_initiator_load_ext.sv
// Combinational load-data extension: keeps the low 8/16/32/64 bits and sign- or zero-extends.
module lsu_load_ext
  import lsu_mem_initiator_pkg::*;
(
  input  logic [63:0] data_i,
  input  size_e       size_i,
  input  logic        unsigned_i,
  output logic [63:0] data_o
);

  always_comb begin
    data_o = data_i;
    case (size_i)
      SizeB:   data_o = {{56{data_i[7] & ~unsigned_i}}, data_i[7:0]};
      SizeH:   data_o = {{48{data_i[15] & ~unsigned_i}}, data_i[15:0]};
      SizeW:   data_o = {{32{data_i[31] & ~unsigned_i}}, data_i[31:0]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Single-outstanding LSU-to-memory-bus initiator: decode, one-cycle bus strobe, wait with
// timeout, load extension and a held response towards the pipeline.
module lsu_mem_initiator
  import lsu_mem_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input logic            clk,
  input logic            rst,
  lsu_mem_initiator_if.master bus
);

  localparam logic [8:0] TimeoutCyc = 9'(TIMEOUT_CYC);

  state_e      state_q, state_d;
  logic [63:0] addr_q, wdata_q;
  size_e       size_q;
  logic        wen_q, unsigned_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [8:0]  cnt_inc;
  logic [63:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic        req_accept;
  logic        mst_valid;
  logic [63:0] ext_data;

  lsu_load_ext u_load_ext (
    .data_i     (bus.mem_data_r),
    .size_i     (size_q),
    .unsigned_i (unsigned_q),
    .data_o     (ext_data)
  );

  assign cnt_inc = {1'b0, cnt_q} + 9'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    req_accept = 1'b0;
    mst_valid  = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.lsu_req_valid) begin
          req_accept = 1'b1;
          if (addr_mapped(bus.lsu_req_addr)) begin
            state_d = StIssue;
          end else begin
            state_d    = StResp;
            rsp_err_d  = 1'b1;
            rsp_data_d = 64'h0;
          end
        end
      end
      StIssue: begin
        if (bus.mem_mstReq_ready) begin
          mst_valid = 1'b1;
          state_d   = StWait;
          cnt_d     = 8'h0;
        end
      end
      StWait: begin
        // A response arriving on the timeout cycle takes priority over the error.
        if (bus.mem_slvRsp_valid) begin
          state_d    = StResp;
          rsp_err_d  = 1'b0;
          rsp_data_d = wen_q ? 64'h0 : ext_data;
        end else if (cnt_inc == TimeoutCyc) begin
          state_d    = StResp;
          rsp_err_d  = 1'b1;
          rsp_data_d = 64'h0;
        end else begin
          cnt_d = cnt_inc[7:0];
        end
      end
      StResp: begin
        if (bus.lsu_rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= 64'h0;
      wdata_q    <= 64'h0;
      size_q     <= SizeB;
      wen_q      <= 1'b0;
      unsigned_q <= 1'b0;
      cnt_q      <= 8'h0;
      rsp_data_q <= 64'h0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      if (req_accept) begin
        addr_q     <= bus.lsu_req_addr;
        wdata_q    <= bus.lsu_req_wdata;
        size_q     <= size_e'(bus.lsu_req_size);
        wen_q      <= bus.lsu_req_wen;
        unsigned_q <= bus.lsu_req_unsigned;
      end
    end
  end

  assign bus.lsu_req_ready    = (state_q == StIdle);
  assign bus.lsu_rsp_valid    = (state_q == StResp);
  assign bus.lsu_rsp_data     = rsp_data_q;
  assign bus.lsu_rsp_err      = rsp_err_q;
  assign bus.mem_mstReq_valid = mst_valid;
  assign bus.mem_addr         = addr_q;
  assign bus.mem_data_w       = wdata_q;
  assign bus.mem_wen          = wen_q;
  assign bus.mem_wstrb        = size_to_wstrb(size_q, wen_q);

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Scoreboard bench for lsu_mem_initiator: expected responses are queued per request and
// compared when the response handshake completes.
module tb_lsu_mem_initiator;

  localparam int unsigned TimeoutCyc = 15;

  logic clk;
  logic rst;
  lsu_mem_initiator_if bus ();

  lsu_mem_initiator #(.TIMEOUT_CYC(TimeoutCyc)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // Observations of the most recent transaction, cycle indices relative to the accept cycle.
  logic        obs_done, obs_unstable, obs_ready_bad, obs_mem_unstable, obs_ready_after;
  int          obs_first, obs_nstrobe, obs_strobe_c, obs_hs_c;
  logic [63:0] obs_data, obs_addr, obs_dataw;
  logic        obs_err, obs_wen;
  logic [7:0]  obs_wstrb;

  task automatic idle_inputs();
    bus.lsu_req_valid    = 1'b0;
    bus.lsu_req_addr     = 64'h0;
    bus.lsu_req_wdata    = 64'h0;
    bus.lsu_req_size     = 2'd0;
    bus.lsu_req_wen      = 1'b0;
    bus.lsu_req_unsigned = 1'b0;
    bus.lsu_rsp_ready    = 1'b0;
    bus.mem_mstReq_ready = 1'b1;
    bus.mem_data_r       = 64'h0;
    bus.mem_slvRsp_valid = 1'b0;
  endtask

  // stall: ISSUE cycles with mem_mstReq_ready low; rsp_at: WAIT cycle of the bus response
  // (0 = silent); hold: cycles lsu_rsp_ready stays low once lsu_rsp_valid rises.
  task automatic run_txn(input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [1:0] size, input logic wen, input logic uns,
                         input int stall, input int rsp_at, input logic [63:0] rdata,
                         input int hold);
    logic         acc;
    logic [136:0] ref_f;
    acc = 1'b0;
    ref_f = '0;
    obs_done = 1'b0; obs_unstable = 1'b0; obs_ready_bad = 1'b0; obs_mem_unstable = 1'b0;
    obs_first = -1; obs_nstrobe = 0; obs_strobe_c = -1; obs_hs_c = -1;
    obs_data = '0; obs_err = 1'b0; obs_addr = '0; obs_dataw = '0; obs_wen = 1'b0;
    obs_wstrb = '0;
    @(posedge clk); #1;
    bus.lsu_req_valid    = 1'b1;
    bus.lsu_req_addr     = addr;
    bus.lsu_req_wdata    = wdata;
    bus.lsu_req_size     = size;
    bus.lsu_req_wen      = wen;
    bus.lsu_req_unsigned = uns;
    for (int c = 0; c < 100 && !obs_done; c++) begin
      bus.mem_mstReq_ready = (c > stall);
      bus.mem_slvRsp_valid = (rsp_at > 0) && (obs_strobe_c >= 0) && (c == obs_strobe_c + rsp_at);
      bus.mem_data_r       = rdata;
      bus.lsu_rsp_ready    = (obs_first >= 0) ? (c >= obs_first + hold) : (hold == 0);
      @(negedge clk);
      if (bus.lsu_req_valid && bus.lsu_req_ready) acc = 1'b1;
      if (bus.mem_mstReq_valid) begin
        obs_nstrobe++;
        if (obs_strobe_c < 0) begin
          obs_strobe_c = c;
          obs_addr     = bus.mem_addr;
          obs_dataw    = bus.mem_data_w;
          obs_wstrb    = bus.mem_wstrb;
          obs_wen      = bus.mem_wen;
        end
      end
      if (c == 1) ref_f = {bus.mem_addr, bus.mem_data_w, bus.mem_wstrb, bus.mem_wen};
      else if (c > 1 && obs_first < 0 &&
               ref_f !== {bus.mem_addr, bus.mem_data_w, bus.mem_wstrb, bus.mem_wen})
        obs_mem_unstable = 1'b1;
      if (bus.lsu_rsp_valid) begin
        if (obs_first < 0) begin
          obs_first = c;
          obs_data  = bus.lsu_rsp_data;
          obs_err   = bus.lsu_rsp_err;
        end else if ({bus.lsu_rsp_data, bus.lsu_rsp_err} !== {obs_data, obs_err}) begin
          obs_unstable = 1'b1;
        end
        if (bus.lsu_req_ready) obs_ready_bad = 1'b1;
        if (bus.lsu_rsp_ready) begin
          obs_done = 1'b1;
          obs_hs_c = c;
        end
      end
      @(posedge clk); #1;
      if (acc) bus.lsu_req_valid = 1'b0;
    end
    bus.lsu_req_valid    = 1'b0;
    bus.mem_slvRsp_valid = 1'b0;
    bus.lsu_rsp_ready    = 1'b0;
    bus.mem_mstReq_ready = 1'b1;
    @(negedge clk);
    obs_ready_after = bus.lsu_req_ready;
  endtask

  task automatic check_rsp(input string name);
    exp_t e;
    e = exp_q.pop_front();
    total++;
    if (obs_done !== 1'b1) begin
      bad++;
      $display("FAIL %s_handshake got=%b want=1", name, obs_done);
    end
    total++;
    if ({obs_data, obs_err} !== {e.data, e.err}) begin
      bad++;
      $display("FAIL %s_rsp got=%h/%b want=%h/%b", name, obs_data, obs_err, e.data, e.err);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.lsu_req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_req_ready got=%b want=1", bus.lsu_req_ready);
    end
    total++;
    if ({bus.lsu_rsp_valid, bus.lsu_rsp_err, bus.mem_mstReq_valid, bus.mem_wen} !== 4'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b%b%b%b want=0000", bus.lsu_rsp_valid, bus.lsu_rsp_err,
               bus.mem_mstReq_valid, bus.mem_wen);
    end
    total++;
    if (bus.lsu_rsp_data !== 64'h0) begin
      bad++;
      $display("FAIL reset_rsp_data got=%h want=0", bus.lsu_rsp_data);
    end
    total++;
    if ({bus.mem_addr, bus.mem_data_w, bus.mem_wstrb} !== 136'h0) begin
      bad++;
      $display("FAIL reset_mem_fields got=%h/%h/%h want=0", bus.mem_addr, bus.mem_data_w,
               bus.mem_wstrb);
    end
  endtask

  task automatic test_load_signed_byte();
    exp_q.push_back('{data: 64'hFFFF_FFFF_FFFF_FF80, err: 1'b0});
    run_txn(64'h8000_0003, 64'h0, 2'd0, 1'b0, 1'b0, 0, 1, 64'h1234_5678_9ABC_0080, 0);
    check_rsp("load_b");
    total++;
    if (obs_first !== 3) begin
      bad++;
      $display("FAIL load_b_latency got=%0d want=3", obs_first);
    end
    total++;
    if ({obs_nstrobe, obs_strobe_c} !== {32'd1, 32'd1}) begin
      bad++;
      $display("FAIL load_b_strobe got=%0d@%0d want=1@1", obs_nstrobe, obs_strobe_c);
    end
    total++;
    if ({obs_addr, obs_wen, obs_wstrb, obs_mem_unstable} !== {64'h8000_0003, 1'b0, 8'h00, 1'b0})
    begin
      bad++;
      $display("FAIL load_b_bus got=%h/%b/%h/%b want=80000003/0/00/0", obs_addr, obs_wen,
               obs_wstrb, obs_mem_unstable);
    end
  endtask

  typedef struct packed {
    logic [1:0]  size;
    logic        uns;
    logic [63:0] rd;
    logic [63:0] want;
  } ext_vec_t;

  task automatic test_load_ext();
    ext_vec_t v[7];
    v[0] = '{size: 2'd1, uns: 1'b0, rd: 64'hAAAA_BBBB_CCCC_8001, want: 64'hFFFF_FFFF_FFFF_8001};
    v[1] = '{size: 2'd1, uns: 1'b1, rd: 64'hAAAA_BBBB_CCCC_8001, want: 64'h0000_0000_0000_8001};
    v[2] = '{size: 2'd2, uns: 1'b0, rd: 64'h1111_2222_8000_0001, want: 64'hFFFF_FFFF_8000_0001};
    v[3] = '{size: 2'd2, uns: 1'b1, rd: 64'h1111_2222_8000_0001, want: 64'h0000_0000_8000_0001};
    v[4] = '{size: 2'd0, uns: 1'b1, rd: 64'hFFFF_FFFF_FFFF_FF80, want: 64'h0000_0000_0000_0080};
    v[5] = '{size: 2'd0, uns: 1'b0, rd: 64'hFFFF_FFFF_FFFF_FF7F, want: 64'h0000_0000_0000_007F};
    v[6] = '{size: 2'd3, uns: 1'b0, rd: 64'h8765_4321_0FED_CBA9, want: 64'h8765_4321_0FED_CBA9};
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back('{data: v[i].want, err: 1'b0});
      run_txn(64'h9000_0000 + 64'(i * 8), 64'h0, v[i].size, 1'b0, v[i].uns, 0, (i % 3) + 1,
              v[i].rd, 0);
      check_rsp($sformatf("ext%0d", i));
      total++;
      if (obs_first !== (i % 3) + 3) begin
        bad++;
        $display("FAIL ext%0d_latency got=%0d want=%0d", i, obs_first, (i % 3) + 3);
      end
    end
  endtask

  task automatic test_store();
    logic [7:0]  strb[4];
    logic [63:0] wd;
    logic [63:0] ad;
    strb[0] = 8'h01; strb[1] = 8'h03; strb[2] = 8'h0F; strb[3] = 8'hFF;
    for (int s = 0; s < 4; s++) begin
      wd = (s == 2) ? 64'h1122_3344 : 64'hA5A5_5A5A_0F0F_F0F0;
      ad = (s == 2) ? 64'h8000_0004 : 64'h8000_0100;
      exp_q.push_back('{data: 64'h0, err: 1'b0});
      run_txn(ad, wd, 2'(s), 1'b1, 1'b0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      check_rsp($sformatf("store%0d", s));
      total++;
      if ({obs_nstrobe, obs_wstrb, obs_wen, obs_dataw, obs_addr} !== {32'd1, strb[s], 1'b1, wd, ad})
      begin
        bad++;
        $display("FAIL store%0d_bus got=%0d/%h/%b/%h/%h want=1/%h/1/%h/%h", s, obs_nstrobe,
                 obs_wstrb, obs_wen, obs_dataw, obs_addr, strb[s], wd, ad);
      end
    end
  endtask

  task automatic test_decode();
    logic [63:0] ad[6];
    logic        mapped[6];
    ad[0] = 64'h0000_0000_7000_0000; mapped[0] = 1'b0;
    ad[1] = 64'h0000_0000_A000_0000; mapped[1] = 1'b0;
    ad[2] = 64'h0000_0001_8000_0000; mapped[2] = 1'b0;
    ad[3] = 64'h0000_0000_0000_0000; mapped[3] = 1'b0;
    ad[4] = 64'h0000_0000_8FFF_FFF8; mapped[4] = 1'b1;
    ad[5] = 64'h0000_0000_9FFF_FFF8; mapped[5] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (mapped[i]) exp_q.push_back('{data: 64'h0123_4567_89AB_CDEF, err: 1'b0});
      else           exp_q.push_back('{data: 64'h0, err: 1'b1});
      run_txn(ad[i], 64'h0, 2'd3, 1'b0, 1'b0, 0, 1, 64'h0123_4567_89AB_CDEF, 0);
      check_rsp($sformatf("decode%0d", i));
      total++;
      if ({obs_first, obs_nstrobe} !== (mapped[i] ? {32'd3, 32'd1} : {32'd1, 32'd0})) begin
        bad++;
        $display("FAIL decode%0d_timing got=%0d/%0d want=%0d/%0d", i, obs_first, obs_nstrobe,
                 mapped[i] ? 3 : 1, mapped[i] ? 1 : 0);
      end
    end
  endtask

  task automatic test_timeout();
    int          at[3];
    logic [63:0] want[3];
    logic        werr[3];
    // Silent, response on the last WAIT cycle, response one cycle too late.
    at[0] = 0;  want[0] = 64'h0;    werr[0] = 1'b1;
    at[1] = 15; want[1] = 64'h7FFF; werr[1] = 1'b0;
    at[2] = 16; want[2] = 64'h0;    werr[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{data: want[i], err: werr[i]});
      run_txn(64'h8000_0040, 64'h0, 2'd1, 1'b0, 1'b0, 0, at[i], 64'h0000_0000_0000_7FFF, 0);
      check_rsp($sformatf("timeout%0d", i));
      total++;
      if (obs_first !== 2 + int'(TimeoutCyc)) begin
        bad++;
        $display("FAIL timeout%0d_latency got=%0d want=%0d", i, obs_first, 2 + TimeoutCyc);
      end
    end
  endtask

  task automatic test_backpressure();
    exp_q.push_back('{data: 64'h0000_0000_1234_5678, err: 1'b0});
    run_txn(64'h8000_0200, 64'h0, 2'd2, 1'b0, 1'b1, 4, 1, 64'hCAFE_F00D_1234_5678, 5);
    check_rsp("bp");
    total++;
    if ({obs_strobe_c, obs_nstrobe, obs_first, obs_hs_c} !== {32'd5, 32'd1, 32'd7, 32'd12}) begin
      bad++;
      $display("FAIL bp_timing got=%0d/%0d/%0d/%0d want=5/1/7/12", obs_strobe_c, obs_nstrobe,
               obs_first, obs_hs_c);
    end
    total++;
    if ({obs_unstable, obs_ready_bad, obs_mem_unstable} !== 3'b000) begin
      bad++;
      $display("FAIL bp_hold got=%b%b%b want=000", obs_unstable, obs_ready_bad, obs_mem_unstable);
    end
  endtask

  task automatic test_back_to_back();
    exp_q.push_back('{data: 64'h0, err: 1'b0});
    run_txn(64'h9000_1000, 64'hDEAD_BEEF, 2'd2, 1'b1, 1'b0, 0, 1, 64'h0, 0);
    check_rsp("b2b_st");
    total++;
    if ({obs_ready_after, obs_ready_bad} !== 2'b10) begin
      bad++;
      $display("FAIL b2b_st_ready got=%b%b want=10", obs_ready_after, obs_ready_bad);
    end
    exp_q.push_back('{data: 64'hFFFF_FFFF_FFFF_FFEF, err: 1'b0});
    run_txn(64'h9000_1000, 64'h0, 2'd0, 1'b0, 1'b0, 0, 2, 64'h0000_0000_0000_00EF, 0);
    check_rsp("b2b_ld");
    total++;
    if ({obs_ready_after, obs_ready_bad, obs_first} !== {2'b10, 32'd4}) begin
      bad++;
      $display("FAIL b2b_ld_ready got=%b%b/%0d want=10/4", obs_ready_after, obs_ready_bad,
               obs_first);
    end
  endtask

  task automatic test_reset_mid();
    logic seen_rsp;
    logic seen_strobe;
    seen_rsp = 1'b0;
    seen_strobe = 1'b0;
    @(posedge clk); #1;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_req_addr  = 64'h8000_0300;
    bus.lsu_req_size  = 2'd3;
    bus.lsu_req_wen   = 1'b0;
    bus.lsu_rsp_ready = 1'b1;
    @(posedge clk); #1;       // ISSUE
    bus.lsu_req_valid = 1'b0;
    @(posedge clk); #1;       // WAIT
    @(posedge clk); #1;       // WAIT, reset sampled at the end of this cycle
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.mem_slvRsp_valid = 1'b1;
    bus.mem_data_r = 64'h5555_AAAA_5555_AAAA;
    @(posedge clk); #1;
    bus.mem_slvRsp_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.lsu_rsp_valid) seen_rsp = 1'b1;
      if (bus.mem_mstReq_valid) seen_strobe = 1'b1;
    end
    total++;
    if ({seen_rsp, seen_strobe, bus.lsu_req_ready} !== 3'b001) begin
      bad++;
      $display("FAIL reset_mid got=%b%b%b want=001", seen_rsp, seen_strobe, bus.lsu_req_ready);
    end
    bus.lsu_rsp_ready = 1'b0;
    exp_q.push_back('{data: 64'h0000_0000_0000_1234, err: 1'b0});
    run_txn(64'h8000_0308, 64'h0, 2'd1, 1'b0, 1'b1, 0, 1, 64'hFFFF_0000_0000_1234, 0);
    check_rsp("after_reset");
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_load_signed_byte();
    test_load_ext();
    test_store();
    test_decode();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
